// File: rtl/timebase_gen.sv
// System timebase: prescaler plus six decade counters that produce registered
// square-wave strobes, single-cycle ticks and a 16-bit running seconds count.
module timebase_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EN,
  input  logic        SYNC,
  output logic        CLK_1MHz,
  output logic        CLK_100kHz,
  output logic        CLK_10Hz,
  output logic        CLK_1Hz,
  output logic        TICK_1MHz,
  output logic        TICK_100kHz,
  output logic        TICK_10Hz,
  output logic        TICK_1Hz,
  output logic [15:0] SEC_CNT
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(DIV / 2);

  logic [PW-1:0]    pre, pre_nx;
  // dig[0] is S1 (100 kHz) ... dig[5] is S6 (1 Hz)
  logic [5:0][3:0]  dig, dig_nx;
  logic [6:0]       carry;
  logic [6:0]       tick_nx;

  // Carries come from the current state so a dropped EN never loses a carry;
  // registered ticks/strobes come from the next state so they match it exactly.
  always_comb begin
    pre_nx   = pre;
    dig_nx   = dig;
    carry    = '0;
    tick_nx  = '0;
    carry[0] = EN & ~SYNC & (pre == PRE_LAST);
    for (int unsigned k = 0; k < 6; k++)
      carry[k+1] = carry[k] & (dig[k] == 4'd9);
    if (EN)
      pre_nx = (pre == PRE_LAST) ? '0 : pre + 1'b1;
    for (int unsigned k = 0; k < 6; k++)
      if (carry[k])
        dig_nx[k] = (dig[k] == 4'd9) ? '0 : dig[k] + 4'd1;
    tick_nx[0] = (pre_nx == PRE_LAST);
    for (int unsigned k = 0; k < 6; k++)
      tick_nx[k+1] = tick_nx[k] & (dig_nx[k] == 4'd9);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre         <= '0;
      dig         <= '0;
      SEC_CNT     <= '0;
      CLK_1MHz    <= 1'b1;
      CLK_100kHz  <= 1'b1;
      CLK_10Hz    <= 1'b1;
      CLK_1Hz     <= 1'b1;
      TICK_1MHz   <= 1'b0;
      TICK_100kHz <= 1'b0;
      TICK_10Hz   <= 1'b0;
      TICK_1Hz    <= 1'b0;
    end else if (SYNC) begin
      pre         <= '0;
      dig         <= '0;
      SEC_CNT     <= '0;
      CLK_1MHz    <= 1'b1;
      CLK_100kHz  <= 1'b1;
      CLK_10Hz    <= 1'b1;
      CLK_1Hz     <= 1'b1;
      TICK_1MHz   <= 1'b0;
      TICK_100kHz <= 1'b0;
      TICK_10Hz   <= 1'b0;
      TICK_1Hz    <= 1'b0;
    end else if (EN) begin
      pre         <= pre_nx;
      dig         <= dig_nx;
      SEC_CNT     <= SEC_CNT + 16'(carry[6]);
      CLK_1MHz    <= (pre_nx < PRE_HALF);
      CLK_100kHz  <= (dig_nx[0] < 4'd5);
      CLK_10Hz    <= (dig_nx[4] < 4'd5);
      CLK_1Hz     <= (dig_nx[5] < 4'd5);
      TICK_1MHz   <= tick_nx[0];
      TICK_100kHz <= tick_nx[1];
      TICK_10Hz   <= tick_nx[5];
      TICK_1Hz    <= tick_nx[6];
    end else begin
      TICK_1MHz   <= 1'b0;
      TICK_100kHz <= 1'b0;
      TICK_10Hz   <= 1'b0;
      TICK_1Hz    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen: DIV=50 instance for phase/enable/sync/reset,
// DIV=2 instance with deposited counter state for the slow ticks and seconds.
module tb_timebase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, en_a = 1'b1, sync_a = 1'b0;
  logic c1m_a, c100k_a, c10_a, c1_a, t1m_a, t100k_a, t10_a, t1_a;
  logic [15:0] sec_a;

  logic rst_b = 1'b0, en_b = 1'b1, sync_b = 1'b0;
  logic c1m_b, c100k_b, c10_b, c1_b, t1m_b, t100k_b, t10_b, t1_b;
  logic [15:0] sec_b;

  timebase_gen dut (
    .CLK(clk), .RESET_N(rst_a), .EN(en_a), .SYNC(sync_a),
    .CLK_1MHz(c1m_a), .CLK_100kHz(c100k_a), .CLK_10Hz(c10_a), .CLK_1Hz(c1_a),
    .TICK_1MHz(t1m_a), .TICK_100kHz(t100k_a), .TICK_10Hz(t10_a), .TICK_1Hz(t1_a),
    .SEC_CNT(sec_a)
  );

  timebase_gen #(.CLK_FREQ_HZ(2_000_000)) dut2 (
    .CLK(clk), .RESET_N(rst_b), .EN(en_b), .SYNC(sync_b),
    .CLK_1MHz(c1m_b), .CLK_100kHz(c100k_b), .CLK_10Hz(c10_b), .CLK_1Hz(c1_b),
    .TICK_1MHz(t1m_b), .TICK_100kHz(t100k_b), .TICK_10Hz(t10_b), .TICK_1Hz(t1_b),
    .SEC_CNT(sec_b)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic to(input int target);
    edges(target - n);
    n = target;
  endtask

  task automatic reset_a();
    rst_a = 1'b0; en_a = 1'b1; sync_a = 1'b0;
    edges(2);
    rst_a = 1'b1;
    n = 0;
  endtask

  task automatic deposit_b(input logic [23:0] digits);
    dut2.pre = '0;
    dut2.dig = digits;
  endtask

  initial begin
    // reset state, while reset is held
    edges(2);
    check("rst_clk1m", 32'(c1m_a), 1);
    check("rst_clk100k", 32'(c100k_a), 1);
    check("rst_clk10", 32'(c10_a), 1);
    check("rst_clk1", 32'(c1_a), 1);
    check("rst_ticks", 32'({t1m_a, t100k_a, t10_a, t1_a}), 0);
    check("rst_sec", 32'(sec_a), 0);
    rst_b = 1'b1;

    // free-running phase, DIV=50
    reset_a();
    to(24);  check("clk1m_n24", 32'(c1m_a), 1);
    to(25);  check("clk1m_n25", 32'(c1m_a), 0);
    to(48);  check("tick1m_n48", 32'(t1m_a), 0);
    to(49);  check("tick1m_n49", 32'(t1m_a), 1);
    check("clk1m_n49", 32'(c1m_a), 0);
    to(50);  check("tick1m_n50", 32'(t1m_a), 0);
    check("clk1m_n50", 32'(c1m_a), 1);
    to(99);  check("tick1m_n99", 32'(t1m_a), 1);
    to(149); check("tick1m_n149", 32'(t1m_a), 1);
    to(249); check("clk100k_n249", 32'(c100k_a), 1);
    to(250); check("clk100k_n250", 32'(c100k_a), 0);
    to(498); check("tick100k_n498", 32'(t100k_a), 0);
    to(499); check("tick100k_n499", 32'(t100k_a), 1);
    check("tick1m_n499", 32'(t1m_a), 1);
    to(500); check("clk100k_n500", 32'(c100k_a), 1);
    check("tick100k_n500", 32'(t100k_a), 0);

    // EN dropped for 100 edges starting at n=10
    reset_a();
    to(10);
    en_a = 1'b0;
    edges(39);
    check("freeze_tick_e49", 32'(t1m_a), 0);
    check("freeze_clk1m_e49", 32'(c1m_a), 1);
    edges(61);
    check("freeze_clk1m_e110", 32'(c1m_a), 1);
    en_a = 1'b1;
    edges(38);
    check("en_tick_e148", 32'(t1m_a), 0);
    edges(1);
    check("en_tick_e149", 32'(t1m_a), 1);

    // SYNC in the cycle that would lead into PRE=49
    reset_a();
    to(48);
    sync_a = 1'b1;
    edges(1);
    sync_a = 1'b0;
    n = 0;
    check("sync48_tick", 32'(t1m_a), 0);
    check("sync48_clk1m", 32'(c1m_a), 1);
    to(49);  check("sync48_retick", 32'(t1m_a), 1);
    // SYNC coincident with terminal PRE and S1 about to advance
    to(449);
    sync_a = 1'b1;
    edges(1);
    sync_a = 1'b0;
    n = 0;
    check("sync449_clk100k", 32'(c100k_a), 1);
    check("sync449_clk1m", 32'(c1m_a), 1);
    check("sync449_tick", 32'(t1m_a), 0);
    // SYNC with EN low still restarts
    to(48);
    sync_a = 1'b1; en_a = 1'b0;
    edges(1);
    sync_a = 1'b0; en_a = 1'b1;
    n = 0;
    check("synccen_clk1m", 32'(c1m_a), 1);
    check("synccen_tick", 32'(t1m_a), 0);
    to(49);  check("synccen_retick", 32'(t1m_a), 1);

    // asynchronous reset between edges at n=37
    reset_a();
    to(37);
    check("pre_async_clk1m", 32'(c1m_a), 0);
    #2;
    rst_a = 1'b0;
    #1;
    check("async_clk1m", 32'(c1m_a), 1);
    check("async_pre", 32'(dut.pre), 0);
    check("async_ticks", 32'({t1m_a, t100k_a, t10_a, t1_a}), 0);
    check("async_sec", 32'(sec_a), 0);
    rst_a = 1'b1;

    // DIV=2: state n=199_990 -> TICK_10Hz at n=199_999
    edges(1);
    deposit_b(24'h099995);
    edges(9);
    check("t10_first", 32'(t10_b), 1);
    check("t10_first_1hz", 32'(t1_b), 0);
    check("t10_first_100k", 32'(t100k_b), 1);
    check("clk10_n199999", 32'(c10_b), 0);
    edges(1);
    check("t10_after", 32'(t10_b), 0);
    check("clk10_n200000", 32'(c10_b), 1);

    // DIV=2: state n=1_999_990 -> TICK_1Hz at n=1_999_999
    deposit_b(24'h999995);
    edges(9);
    check("t1_first", 32'({t1_b, t10_b, t100k_b, t1m_b}), 32'hF);
    check("sec_before", 32'(sec_b), 0);
    check("clk1hz_low", 32'(c1_b), 0);
    edges(1);
    check("sec_1", 32'(sec_b), 1);
    check("t1_after", 32'(t1_b), 0);
    check("clk1hz_rise", 32'(c1_b), 1);
    // n=3_999_990 has the same counter state
    deposit_b(24'h999995);
    edges(10);
    check("sec_2", 32'(sec_b), 2);

    // seconds wrap from 65535
    deposit_b(24'h999995);
    dut2.SEC_CNT = 16'hFFFF;
    edges(9);
    check("sec_hold_ffff", 32'(sec_b), 32'hFFFF);
    check("wrap_t1", 32'(t1_b), 1);
    edges(1);
    check("sec_wrap", 32'(sec_b), 0);
    check("wrap_clks", 32'({c1m_b, c100k_b, c10_b, c1_b}), 32'hF);
    check("wrap_ticks", 32'({t1m_b, t100k_b, t10_b, t1_b}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timebase_gen.md
# timebase_gen

Generates the system timebase consumed by downstream application blocks: 50 %-duty square-wave strobes CLK_1MHz, CLK_100kHz, CLK_10Hz and CLK_1Hz, plus single-cycle tick pulses at the same rates, all derived from the one system clock CLK. Consumers sample these strobes on CLK and detect their edges. The block also keeps a 16-bit running seconds count. It sits at top level, next to the clock input, and fans out to every application block.

## Interface
- CLK_FREQ_HZ, 50_000_000, frequency of CLK. Must be a multiple of 2 MHz. DIV = CLK_FREQ_HZ / 1_000_000 is even and ≥ 2.
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; 0 freezes the whole timebase.
- SYNC  in  1  synchronous phase restart; clears all counters.
- CLK_1MHz, CLK_100kHz, CLK_10Hz, CLK_1Hz  out  1 each  square-wave strobes.
- TICK_1MHz, TICK_100kHz, TICK_10Hz, TICK_1Hz  out  1 each  one-CLK-cycle pulses.
- SEC_CNT  out  16  seconds counter.

## Operation
- Prescaler PRE counts 0..DIV-1.
- Six decade counters S1..S6 each count 0..9:
  - S1 advances on the 1 MHz tick; its wrap is the 100 kHz tick.
  - S2 → 10 kHz, S3 → 1 kHz, S4 → 100 Hz (all internal).
  - S5 → 10 Hz, S6 → 1 Hz.
- Tick definitions:
  - TICK_1MHz = EN & !SYNC & (PRE == DIV-1).
  - TICK_100kHz = TICK_1MHz & (S1 == 9).
  - TICK_10Hz = 100 Hz tick & (S5 == 9).
  - TICK_1Hz = TICK_10Hz & (S6 == 9).
  - Ticks are nested, so each slower tick coincides with a faster tick.
- Square-wave definitions:
  - CLK_1MHz = (PRE < DIV/2).
  - CLK_100kHz = (S1 < 5).
  - CLK_10Hz = (S5 < 5).
  - CLK_1Hz = (S6 < 5).
- Every output is driven from flops. The next value is computed from the next counter state, so outputs are exact functions of the current counter state with no combinational output path.
- A counter advances only when its input tick is high. It wraps to 0 at its terminal value.
- SEC_CNT increments on every edge where TICK_1Hz = 1 and wraps from 65535 to 0.
- Input priority, per edge:
  - SYNC = 1: PRE, S1..S6 and SEC_CNT are cleared to 0; all ticks are 0; all CLK_* go to 1. SYNC wins over EN and over a coincident terminal count.
  - EN = 0 (SYNC = 0): all counters hold, all ticks are 0, and all CLK_* hold their level.
  - Otherwise: normal counting.
- Reset (RESET_N = 0, any time, mid-period included) takes effect immediately, without a clock:
  - PRE, S1..S6 and SEC_CNT = 0.
  - All CLK_* = 1.
  - All TICK_* = 0.

## Timing
- Cycle numbering: n = number of rising edges with EN = 1 since reset release or since the last SYNC.
- Counter states: PRE = n mod DIV; S1 = floor(n/DIV) mod 10; and so on.
- TICK_1MHz is first high in the cycle after edge DIV-1. Period DIV cycles; width 1 cycle.
- CLK_1MHz: high for DIV/2 cycles, then low for DIV/2 cycles. Its rising edge is aligned to PRE = 0.
- CLK_100kHz: period 10·DIV cycles; high 5·DIV, low 5·DIV.
- CLK_10Hz: period 10^6·DIV / 10 cycles.
- CLK_1Hz: period 10^6·DIV cycles.
- TICK_1Hz is first high in the cycle where n = 10^6·DIV − 1. SEC_CNT becomes 1 at the following edge.
- Cycles with EN = 0 stretch all periods by exactly the number of disabled cycles. Phase is otherwise preserved.
- SYNC latency is 1 edge. Counting resumes at the next edge with EN = 1 and SYNC = 0, starting from n = 0.

## Test plan
- Async reset: assert RESET_N low at n = 37 (DIV = 50), between edges → immediately PRE = 0, all CLK_* = 1, all TICK_* = 0, SEC_CNT = 0, with no clock edge needed.
- DIV = 50, EN = 1 from reset → TICK_1MHz high at n = 49, 99, 149. CLK_1MHz is high for n 0..24 and low for n 25..49. TICK_100kHz is first high at n = 499. CLK_100kHz falls at n = 250 and rises at n = 500.
- Override CLK_FREQ_HZ = 2_000_000 (DIV = 2), EN = 1:
  - TICK_10Hz first at n = 199_999.
  - TICK_1Hz first at n = 1_999_999, coincident with TICK_10Hz, TICK_100kHz and TICK_1MHz.
  - SEC_CNT = 1 after that edge and SEC_CNT = 2 at n = 4_000_000.
- DIV = 50: drop EN for 100 cycles starting at n = 10 → all outputs frozen for 100 cycles. Next TICK_1MHz arrives 149 cycles after reset release instead of 49.
- DIV = 50: pulse SYNC for 1 cycle in the cycle where PRE = 49 → no TICK_1MHz that cycle, PRE = 0 afterwards, CLK_1MHz = 1. Repeat with EN = 0 during the SYNC cycle → same result.
- Preload SEC_CNT = 65535 (DIV = 2, SEC_CNT forced via hierarchical deposit), then run to the next TICK_1Hz → SEC_CNT = 0, no other output disturbed.
